// File: rtl/line_tool_pkg.sv
// Shared types and constants for the line drawing tool.
package line_tool_pkg;

  // Width of a palette colour index on the canvas write port.
  localparam int unsigned COLOR_WIDTH = 8;

  // Line tool FSM: waiting for cursor motion, or walking a line one pixel per clock.
  typedef enum logic [0:0] {
    LineIdle,
    LineDraw
  } line_state_t;

endpackage

// File: rtl/line_tool_stepper.sv
// One Bresenham step: from the current point and error term, produce the next point and error.
// Purely combinational so it can be exercised on its own.
module line_tool_stepper #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9,
  parameter int unsigned AW = 12
) (
  input  logic [XW-1:0]        cur_x_i,
  input  logic [YW-1:0]        cur_y_i,
  input  logic signed [AW-1:0] err_i,
  input  logic signed [AW-1:0] dx_i,     // |x1-x0|, non-negative
  input  logic signed [AW-1:0] dy_i,     // -|y1-y0|, non-positive
  input  logic                 sx_i,     // 1: x walks downwards
  input  logic                 sy_i,     // 1: y walks downwards
  output logic [XW-1:0]        next_x_o,
  output logic [YW-1:0]        next_y_o,
  output logic signed [AW-1:0] next_err_o
);

  logic signed [AW:0] e2;
  logic signed [AW:0] dx_ext;
  logic signed [AW:0] dy_ext;
  logic               step_x;
  logic               step_y;

  // Both axis decisions use the pre-step error term.
  always_comb begin
    e2         = $signed({err_i, 1'b0});
    dx_ext     = $signed({dx_i[AW-1], dx_i});
    dy_ext     = $signed({dy_i[AW-1], dy_i});
    step_x     = (e2 >= dy_ext);
    step_y     = (e2 <= dx_ext);
    next_err_o = err_i;
    next_x_o   = cur_x_i;
    next_y_o   = cur_y_i;
    if (step_x) begin
      next_err_o = next_err_o + dy_i;
      next_x_o   = sx_i ? (cur_x_i - XW'(1)) : (cur_x_i + XW'(1));
    end
    if (step_y) begin
      next_err_o = next_err_o + dx_i;
      next_y_o   = sy_i ? (cur_y_i - YW'(1)) : (cur_y_i + YW'(1));
    end
  end

endmodule

// File: rtl/line_tool.sv
// Line drawing tool: joins successive pen-down cursor samples with gap-free lines,
// emitting one canvas pixel write per clock.
module line_tool
  import line_tool_pkg::*;
#(
  parameter int unsigned Width  = 640,
  parameter int unsigned Height = 480,
  localparam int unsigned XW    = $clog2(Width),
  localparam int unsigned YW    = $clog2(Height)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [XW-1:0]          cursor_x_i,
  input  logic [YW-1:0]          cursor_y_i,
  input  logic [COLOR_WIDTH-1:0] input_color_i,
  output logic [XW-1:0]          pixel_x_o,
  output logic [YW-1:0]          pixel_y_o,
  output logic [COLOR_WIDTH-1:0] pixel_color_o,
  output logic                   pixel_valid_o,
  output logic                   busy_o
);

  // Signed arithmetic width: one bit for sign, one for the doubled error term headroom.
  localparam int unsigned AW = ((XW > YW) ? XW : YW) + 2;

  line_state_t             state_q;
  logic                    pen_down_q;
  logic [XW-1:0]           last_x_q, cur_x_q, end_x_q, pixel_x_q;
  logic [YW-1:0]           last_y_q, cur_y_q, end_y_q, pixel_y_q;
  logic [COLOR_WIDTH-1:0]  color_q, pixel_color_q;
  logic                    pixel_valid_q;
  logic signed [AW-1:0]    err_q, dx_q, dy_q;
  logic                    sx_q, sy_q;

  logic signed [AW-1:0]    x0_s, x1_s, y0_s, y1_s, x_diff, y_diff;
  logic signed [AW-1:0]    load_dx, load_dy;
  logic                    load_sx, load_sy;
  logic                    at_last, at_end;
  logic [XW-1:0]           next_x;
  logic [YW-1:0]           next_y;
  logic signed [AW-1:0]    next_err;

  // Line setup from the last pen position to the current cursor.
  always_comb begin
    x0_s    = $signed({{(AW-XW){1'b0}}, last_x_q});
    x1_s    = $signed({{(AW-XW){1'b0}}, cursor_x_i});
    y0_s    = $signed({{(AW-YW){1'b0}}, last_y_q});
    y1_s    = $signed({{(AW-YW){1'b0}}, cursor_y_i});
    x_diff  = x1_s - x0_s;
    y_diff  = y1_s - y0_s;
    load_sx = x_diff[AW-1];
    load_sy = y_diff[AW-1];
    load_dx = load_sx ? -x_diff : x_diff;
    load_dy = load_sy ? y_diff : -y_diff;
    at_last = (cursor_x_i == last_x_q) && (cursor_y_i == last_y_q);
    at_end  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
  end

  line_tool_stepper #(
    .XW (XW),
    .YW (YW),
    .AW (AW)
  ) u_stepper (
    .cur_x_i    (cur_x_q),
    .cur_y_i    (cur_y_q),
    .err_i      (err_q),
    .dx_i       (dx_q),
    .dy_i       (dy_q),
    .sx_i       (sx_q),
    .sy_i       (sy_q),
    .next_x_o   (next_x),
    .next_y_o   (next_y),
    .next_err_o (next_err)
  );

  // FSM, line walker and registered write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= LineIdle;
      pen_down_q    <= 1'b0;
      last_x_q      <= '0;
      last_y_q      <= '0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      end_x_q       <= '0;
      end_y_q       <= '0;
      color_q       <= '0;
      err_q         <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      sx_q          <= 1'b0;
      sy_q          <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_color_q <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        LineIdle: begin
          if (!enable_i) begin
            pen_down_q    <= 1'b0;
            pixel_valid_q <= 1'b0;
          end else if (!pen_down_q) begin
            // Fresh press: a single dot, and it becomes the anchor for the next line.
            pixel_x_q     <= cursor_x_i;
            pixel_y_q     <= cursor_y_i;
            pixel_color_q <= input_color_i;
            pixel_valid_q <= 1'b1;
            last_x_q      <= cursor_x_i;
            last_y_q      <= cursor_y_i;
            pen_down_q    <= 1'b1;
          end else if (at_last) begin
            pixel_valid_q <= 1'b0;
          end else begin
            cur_x_q       <= last_x_q;
            cur_y_q       <= last_y_q;
            end_x_q       <= cursor_x_i;
            end_y_q       <= cursor_y_i;
            color_q       <= input_color_i;
            dx_q          <= load_dx;
            dy_q          <= load_dy;
            sx_q          <= load_sx;
            sy_q          <= load_sy;
            err_q         <= load_dx + load_dy;
            pixel_valid_q <= 1'b0;
            state_q       <= LineDraw;
          end
        end
        LineDraw: begin
          pixel_x_q     <= cur_x_q;
          pixel_y_q     <= cur_y_q;
          pixel_color_q <= color_q;
          pixel_valid_q <= 1'b1;
          if (at_end) begin
            last_x_q   <= end_x_q;
            last_y_q   <= end_y_q;
            pen_down_q <= enable_i;
            state_q    <= LineIdle;
          end else begin
            cur_x_q <= next_x;
            cur_y_q <= next_y;
            err_q   <= next_err;
          end
        end
        default: state_q <= LineIdle;
      endcase
    end
  end

  // Outputs: write port is registered, busy follows the state directly.
  always_comb begin
    pixel_x_o     = pixel_x_q;
    pixel_y_o     = pixel_y_q;
    pixel_color_o = pixel_color_q;
    pixel_valid_o = pixel_valid_q;
    busy_o        = (state_q == LineDraw);
  end

endmodule

// File: tb/tb_line_tool.sv
// Self-checking bench for line_tool: directed scenarios then random pen strokes,
// each compared against a transaction-level model of the tool.
module tb_line_tool;
  import line_tool_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   enable;
  logic [9:0]             cursor_x;
  logic [8:0]             cursor_y;
  logic [COLOR_WIDTH-1:0] input_color;
  logic [9:0]             pixel_x;
  logic [8:0]             pixel_y;
  logic [COLOR_WIDTH-1:0] pixel_color;
  logic                   pixel_valid;
  logic                   busy;

  int checks   = 0;
  int failures = 0;

  // Model of the tool's persistent state between strokes.
  bit m_pen = 0;
  int m_lx  = 0;
  int m_ly  = 0;

  line_tool #(
    .Width  (640),
    .Height (480)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .cursor_x_i    (cursor_x),
    .cursor_y_i    (cursor_y),
    .input_color_i (input_color),
    .pixel_x_o     (pixel_x),
    .pixel_y_o     (pixel_y),
    .pixel_color_o (pixel_color),
    .pixel_valid_o (pixel_valid),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Gap-free line from (x0,y0) to (x1,y1) as a list of points.
  task automatic make_line(input int x0, input int y0, input int x1, input int y1,
                           output int qx[$], output int qy[$]);
    int x, y, dx, dy, sx, sy, err, e2;
    qx = {};
    qy = {};
    x  = x0;
    y  = y0;
    dx = iabs(x1 - x0);
    dy = -iabs(y1 - y0);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    for (int k = 0; k < 4096; k++) begin
      qx.push_back(x);
      qy.push_back(y);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cursor sample; if it starts a line, hold (men,mx,my,mc) on the inputs while
  // the line is walked and check every emitted pixel.
  task automatic do_step(input bit en, input int x, input int y, input int c,
                         input bit men, input int mx, input int my, input int mc);
    int qx[$];
    int qy[$];
    int n;
    enable      = en;
    cursor_x    = 10'(x);
    cursor_y    = 9'(y);
    input_color = COLOR_WIDTH'(c);
    tick();
    if (!en) begin
      chk("penup_valid", 32'(pixel_valid), 0);
      chk("penup_busy", 32'(busy), 0);
      m_pen = 0;
    end else if (!m_pen) begin
      chk("dot_valid", 32'(pixel_valid), 1);
      chk("dot_x", 32'(pixel_x), 32'(x));
      chk("dot_y", 32'(pixel_y), 32'(y));
      chk("dot_color", 32'(pixel_color), 32'(c));
      chk("dot_busy", 32'(busy), 0);
      m_pen = 1;
      m_lx  = x;
      m_ly  = y;
    end else if (x == m_lx && y == m_ly) begin
      chk("still_valid", 32'(pixel_valid), 0);
      chk("still_busy", 32'(busy), 0);
    end else begin
      chk("load_valid", 32'(pixel_valid), 0);
      chk("load_busy", 32'(busy), 1);
      make_line(m_lx, m_ly, x, y, qx, qy);
      n = qx.size();
      enable      = men;
      cursor_x    = 10'(mx);
      cursor_y    = 9'(my);
      input_color = COLOR_WIDTH'(mc);
      for (int i = 0; i < n; i++) begin
        tick();
        chk("line_valid", 32'(pixel_valid), 1);
        chk("line_x", 32'(pixel_x), 32'(qx[i]));
        chk("line_y", 32'(pixel_y), 32'(qy[i]));
        chk("line_color", 32'(pixel_color), 32'(c));
        chk("line_busy", 32'(busy), (i < n - 1) ? 1 : 0);
      end
      // Directly check the emitted length against the longer axis span.
      chk("line_len", 32'(n), 32'(((iabs(x - m_lx) > iabs(y - m_ly)) ?
                                   iabs(x - m_lx) : iabs(y - m_ly)) + 1));
      m_pen = men;
      m_lx  = x;
      m_ly  = y;
    end
  endtask

  initial begin
    int nx, ny;
    bit en, men;
    rst_n       = 1'b0;
    enable      = 1'b0;
    cursor_x    = '0;
    cursor_y    = '0;
    input_color = '0;
    #1;
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x", 32'(pixel_x), 0);
    chk("rst_y", 32'(pixel_y), 0);
    chk("rst_color", 32'(pixel_color), 0);
    #22;
    rst_n = 1'b1;

    // Single dot, then no repeat writes while the cursor rests.
    do_step(1, 5, 7, 3, 1, 5, 7, 3);
    do_step(1, 5, 7, 3, 1, 5, 7, 3);
    do_step(1, 5, 7, 3, 1, 5, 7, 3);

    // Horizontal line (2,3)->(6,3), then steep line with negative x to (4,8).
    do_step(0, 5, 7, 3, 0, 0, 0, 0);
    do_step(1, 2, 3, 9, 1, 2, 3, 9);
    do_step(1, 6, 3, 9, 1, 6, 3, 9);
    do_step(1, 4, 8, 12, 1, 4, 8, 12);

    // Diagonal with the cursor moved mid-line; the new point then draws from (7,7).
    do_step(0, 0, 0, 0, 0, 0, 0, 0);
    do_step(1, 0, 0, 1, 1, 0, 0, 1);
    do_step(1, 7, 7, 2, 1, 20, 1, 77);
    do_step(1, 20, 1, 4, 1, 20, 1, 4);

    // Enable dropped during a 10-pixel line, then a far press gives only a dot.
    do_step(1, 29, 5, 6, 0, 29, 5, 6);
    do_step(1, 300, 200, 8, 1, 300, 200, 8);

    // Reset asserted on the third pixel of a line aborts it immediately.
    enable   = 1'b1;
    cursor_x = 10'd310;
    cursor_y = 9'd200;
    tick();
    chk("abort_load_busy", 32'(busy), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_pix_valid", 32'(pixel_valid), 1);
      chk("abort_pix_x", 32'(pixel_x), 32'(300 + k));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(pixel_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(pixel_valid), 0);
    m_pen = 0;
    m_lx  = 0;
    m_ly  = 0;
    do_step(1, 50, 60, 5, 1, 50, 60, 5);

    // Random strokes, including out-of-range cursors and mid-line input churn.
    for (int r = 0; r < 60; r++) begin
      en  = ($urandom_range(0, 9) != 0);
      men = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        nx = m_lx;
        ny = m_ly;
      end else begin
        nx = m_lx + int'($urandom_range(0, 60)) - 30;
        ny = m_ly + int'($urandom_range(0, 60)) - 30;
      end
      if (nx < 0) nx = 0;
      if (nx > 1023) nx = 1023;
      if (ny < 0) ny = 0;
      if (ny > 511) ny = 511;
      do_step(en, nx, ny, int'($urandom_range(0, 255)), men,
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
